krnl_acc_tile_sched: RTL and testbench
======================================

# krnl_acc_tile_sched

Tile-level sequencer for the convolution accelerator kernel. It sits between the AXI-Lite control slave and the datapath/DMA engines. It accepts the ap_ctrl_chain start, latches the layer configuration, and for each tile issues IFM and WGT read commands, a compute start and an OFM write command. When all tiles are finished it returns ap_done/ap_idle/ap_ready to the control slave.

## Interface
- No parameters; widths are fixed by the control register map: 32-bit sizes/config, 64-bit addresses.
- ACLK  in  1  kernel clock, all logic on the rising edge
- ARESETn  in  1  synchronous, active-low reset
- ap_start  in  1  level; run requested
- ap_continue  in  1  one-cycle pulse; acknowledges done
- ap_done / ap_idle / ap_ready  out  1 each  ap_ctrl_chain status
- cfg_ci, cfg_co  in  32  channel config, forwarded to compute
- ifm_size, wgt_size, ofm_size  in  32  bytes per tile for each stream
- tile_num  in  32  number of tiles
- ifm_addr_base, wgt_addr_base, ofm_addr_base  in  64  buffer base addresses
- rd_cmd_valid  out  1  read command valid
- rd_cmd_ready  in  1  read command ready
- rd_cmd_addr  out  64  read command address
- rd_cmd_len  out  32  read command length in bytes
- rd_cmd_sel  out  1  0 = IFM, 1 = WGT
- rd_done  in  1  one pulse per completed read command
- comp_start  out  1  one-cycle pulse; starts compute for the tile
- comp_ci, comp_co  out  32  latched cfg_ci/cfg_co
- comp_done  in  1  pulse; compute for the tile finished
- wr_cmd_valid  out  1  write command valid
- wr_cmd_ready  in  1  write command ready
- wr_cmd_addr  out  64  write command address
- wr_cmd_len  out  32  write command length in bytes
- wr_done  in  1  pulse; OFM write committed

## Operation
- States: IDLE, RD_IFM, RD_WGT, WAIT_RD, COMP, WAIT_COMP, WR_OFM, WAIT_WR, NEXT, DONE.
- IDLE:
  - ap_idle=1.
  - On ap_start=1: latch all cfg/size/base inputs, clear tile counter t, pulse ap_ready.
  - If tile_num==0, go to DONE; otherwise go to RD_IFM.
- RD_IFM: rd_cmd_valid=1, sel=0, addr=ifm_ptr, len=ifm_size. Hold until rd_cmd_ready, then go to RD_WGT.
- RD_WGT: same pattern with sel=1, addr=wgt_ptr, len=wgt_size, then go to WAIT_RD.
- Zero-length streams: if a size is 0, skip that command; it counts as already completed.
- rd_done counting:
  - A 2-bit outstanding counter increments on each read command handshake and decrements on rd_done.
  - A handshake and an rd_done in the same cycle leave the counter unchanged.
  - WAIT_RD exits to COMP when the counter is 0.
- COMP: one-cycle comp_start, then go to WAIT_COMP. WAIT_COMP exits on comp_done.
- WR_OFM: wr_cmd_valid with addr=ofm_ptr, len=ofm_size. On handshake go to WAIT_WR, which exits on wr_done. If ofm_size==0, go straight to NEXT.
- NEXT:
  - Each pointer advances by its size; 64-bit modulo-2^64 add, size zero-extended. t increments.
  - If t+1==tile_num go to DONE, else go to RD_IFM.
- DONE: ap_done held high. On ap_continue go to IDLE.
- Ignored inputs:
  - ap_continue outside DONE.
  - ap_start outside IDLE.
  - Spurious rd_done/comp_done/wr_done in any state that does not wait on them. The read counter never underflows; it saturates at 0.
- valid/addr/len are stable while valid=1 and ready=0.

## Timing
- Reset values: ap_idle=1; all other outputs 0, including all addr/len/comp_c*. State IDLE, counters 0.
- Reset mid-run: state returns to IDLE the cycle after ARESETn is sampled low. All command valids drop.
- ap_start sampled at cycle N:
  - N+1: ap_ready=1 for exactly one cycle, ap_idle=0, rd_cmd_valid=1 (ifm_size≠0).
- Command handshake at cycle M: the next command's valid is asserted at M+1. No back-to-back handshakes on the same cycle.
- WAIT_RD→COMP takes 1 cycle after the last rd_done. comp_start occurs 1 cycle after entering COMP.
- ap_done rises 1 cycle after NEXT of the last tile, or 1 cycle after ap_ready when tile_num==0.
- ap_continue at cycle K: ap_done=0 and ap_idle=1 at K+1.

## Structure
- Shared package krnl_acc_pkg holds:
  - the state enum;
  - constants RD_SEL_IFM=1'b0 and RD_SEL_WGT=1'b1;
  - address width 64 and size width 32.
- One sub-module, krnl_acc_tile_ptr: holds three 64-bit pointers with load-from-base and add-size-on-advance. All FSM logic stays in the top.

## Test plan
- **Single tile:** tile_num=1, ifm_base=0x1000, sizes 0x100/0x40/0x80, ready always high.
  - Expect: IFM cmd (0x1000,0x100), then WGT cmd, then comp_start, then write cmd (ofm_base,0x80).
  - Expect: ap_ready pulse at N+1; ap_done after wr_done.
- **Three tiles with backpressure:** rd_cmd_ready low for 5 cycles per command.
  - Expect: addresses ifm_base+0/+0x100/+0x200, command fields stable while stalled, exactly 3 comp_start pulses.
- **tile_num=0:** ap_ready at N+1, ap_done at N+2, no commands issued.
- **Coincident and early completion:** rd_done arrives in the same cycle as the WGT handshake.
  - Expect: counter stays correct; COMP is entered only after both rd_done pulses.
- **ap_ctrl_chain hold:** ap_start kept high through DONE with ap_continue delayed 20 cycles.
  - Expect: ap_done held high and no new run starts. After ap_continue, idle at K+1 and a new run starts in the next cycle.
- **Reset mid-run:** ARESETn low during WAIT_COMP.
  - Expect: all outputs at reset values the next cycle; a late comp_done is ignored.
- **Pointer wrap:** base=0xFFFF_FFFF_FFFF_FF00, size 0x100, 2 tiles.
  - Expect: second IFM address is 0x0.

Source files
------------

// File: rtl/krnl_acc_pkg.sv
// Shared types and constants for the convolution accelerator tile sequencer.
package krnl_acc_pkg;

    localparam int ADDR_W = 64;
    localparam int SIZE_W = 32;

    localparam logic RD_SEL_IFM = 1'b0;
    localparam logic RD_SEL_WGT = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RD_IFM,
        ST_RD_WGT,
        ST_WAIT_RD,
        ST_COMP,
        ST_WAIT_COMP,
        ST_WR_OFM,
        ST_WAIT_WR,
        ST_NEXT,
        ST_DONE
    } state_t;

    function automatic logic [ADDR_W-1:0] size_to_addr(input logic [SIZE_W-1:0] size);
        return {{(ADDR_W-SIZE_W){1'b0}}, size};
    endfunction

endpackage

// File: rtl/krnl_acc_tile_ptr.sv
// Per-stream buffer pointers (IFM, WGT, OFM): load from base, advance by tile size.
module krnl_acc_tile_ptr
    import krnl_acc_pkg::*;
(
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              load,
    input  logic              advance,
    input  logic [ADDR_W-1:0] ifm_base,
    input  logic [ADDR_W-1:0] wgt_base,
    input  logic [ADDR_W-1:0] ofm_base,
    input  logic [SIZE_W-1:0] ifm_size,
    input  logic [SIZE_W-1:0] wgt_size,
    input  logic [SIZE_W-1:0] ofm_size,
    output logic [ADDR_W-1:0] wgt_ptr,
    output logic [ADDR_W-1:0] ofm_ptr,
    output logic [ADDR_W-1:0] ifm_ptr_adv,
    output logic [ADDR_W-1:0] wgt_ptr_adv
);

    logic [ADDR_W-1:0] base_arr [3];
    logic [SIZE_W-1:0] size_arr [3];
    logic [ADDR_W-1:0] ptr_reg  [3];
    logic [ADDR_W-1:0] ptr_next [3];

    assign base_arr[0] = ifm_base;
    assign base_arr[1] = wgt_base;
    assign base_arr[2] = ofm_base;
    assign size_arr[0] = ifm_size;
    assign size_arr[1] = wgt_size;
    assign size_arr[2] = ofm_size;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_ptr
            // Modulo-2^64 wrap is intentional: buffers may straddle the top of the address space.
            assign ptr_next[gi] = ptr_reg[gi] + size_to_addr(size_arr[gi]);

            always_ff @(posedge ACLK) begin
                if (!ARESETn) begin
                    ptr_reg[gi] <= '0;
                end else if (load) begin
                    ptr_reg[gi] <= base_arr[gi];
                end else if (advance) begin
                    ptr_reg[gi] <= ptr_next[gi];
                end
            end
        end
    endgenerate

    assign wgt_ptr     = ptr_reg[1];
    assign ofm_ptr     = ptr_reg[2];
    assign ifm_ptr_adv = ptr_next[0];
    assign wgt_ptr_adv = ptr_next[1];

endmodule

// File: rtl/krnl_acc_tile_sched.sv
// Tile sequencer: ap_ctrl_chain handshake, per-tile IFM/WGT reads, compute kick and OFM write.
module krnl_acc_tile_sched
    import krnl_acc_pkg::*;
(
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              ap_start,
    input  logic              ap_continue,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    input  logic [SIZE_W-1:0] cfg_ci,
    input  logic [SIZE_W-1:0] cfg_co,
    input  logic [SIZE_W-1:0] ifm_size,
    input  logic [SIZE_W-1:0] wgt_size,
    input  logic [SIZE_W-1:0] ofm_size,
    input  logic [SIZE_W-1:0] tile_num,
    input  logic [ADDR_W-1:0] ifm_addr_base,
    input  logic [ADDR_W-1:0] wgt_addr_base,
    input  logic [ADDR_W-1:0] ofm_addr_base,
    output logic              rd_cmd_valid,
    input  logic              rd_cmd_ready,
    output logic [ADDR_W-1:0] rd_cmd_addr,
    output logic [SIZE_W-1:0] rd_cmd_len,
    output logic              rd_cmd_sel,
    input  logic              rd_done,
    output logic              comp_start,
    output logic [SIZE_W-1:0] comp_ci,
    output logic [SIZE_W-1:0] comp_co,
    input  logic              comp_done,
    output logic              wr_cmd_valid,
    input  logic              wr_cmd_ready,
    output logic [ADDR_W-1:0] wr_cmd_addr,
    output logic [SIZE_W-1:0] wr_cmd_len,
    input  logic              wr_done
);

    state_t            state_reg;
    logic              ap_done_reg, ap_idle_reg, ap_ready_reg;
    logic              rd_cmd_valid_reg, rd_cmd_sel_reg;
    logic [ADDR_W-1:0] rd_cmd_addr_reg;
    logic [SIZE_W-1:0] rd_cmd_len_reg;
    logic              comp_start_reg;
    logic [SIZE_W-1:0] comp_ci_reg, comp_co_reg;
    logic              wr_cmd_valid_reg;
    logic [ADDR_W-1:0] wr_cmd_addr_reg;
    logic [SIZE_W-1:0] wr_cmd_len_reg;
    logic [SIZE_W-1:0] ifm_size_reg, wgt_size_reg, ofm_size_reg, tile_num_reg;
    logic [SIZE_W-1:0] tile_cnt_reg;
    logic [1:0]        rd_out_reg, rd_out_next;

    logic              rd_hs;
    logic              ptr_load, ptr_adv;
    logic [ADDR_W-1:0] wgt_ptr, ofm_ptr, ifm_ptr_adv, wgt_ptr_adv;

    logic [SIZE_W-1:0] fr_ifm_len, fr_wgt_len;
    logic [ADDR_W-1:0] fr_ifm_addr, fr_wgt_addr;
    state_t            first_state;
    logic              first_valid, first_sel;
    logic [ADDR_W-1:0] first_addr;
    logic [SIZE_W-1:0] first_len;

    assign rd_hs    = rd_cmd_valid_reg & rd_cmd_ready;
    assign ptr_load = (state_reg == ST_IDLE) && ap_start;
    assign ptr_adv  = (state_reg == ST_NEXT);

    krnl_acc_tile_ptr u_ptr (
        .ACLK        (ACLK),
        .ARESETn     (ARESETn),
        .load        (ptr_load),
        .advance     (ptr_adv),
        .ifm_base    (ifm_addr_base),
        .wgt_base    (wgt_addr_base),
        .ofm_base    (ofm_addr_base),
        .ifm_size    (ifm_size_reg),
        .wgt_size    (wgt_size_reg),
        .ofm_size    (ofm_size_reg),
        .wgt_ptr     (wgt_ptr),
        .ofm_ptr     (ofm_ptr),
        .ifm_ptr_adv (ifm_ptr_adv),
        .wgt_ptr_adv (wgt_ptr_adv)
    );

    // Outstanding reads; a coincident handshake and rd_done cancel, and it never underflows.
    always_comb begin
        rd_out_next = rd_out_reg;
        if (rd_hs && !rd_done) begin
            rd_out_next = rd_out_reg + 2'd1;
        end else if (!rd_hs && rd_done && rd_out_reg != 2'd0) begin
            rd_out_next = rd_out_reg - 2'd1;
        end
    end

    // First read of a tile, issued from IDLE (live inputs) or NEXT (advanced pointers); zero sizes are skipped.
    always_comb begin
        fr_ifm_len  = (state_reg == ST_IDLE) ? ifm_size      : ifm_size_reg;
        fr_wgt_len  = (state_reg == ST_IDLE) ? wgt_size      : wgt_size_reg;
        fr_ifm_addr = (state_reg == ST_IDLE) ? ifm_addr_base : ifm_ptr_adv;
        fr_wgt_addr = (state_reg == ST_IDLE) ? wgt_addr_base : wgt_ptr_adv;
        first_state = ST_WAIT_RD;
        first_valid = 1'b0;
        first_sel   = RD_SEL_IFM;
        first_addr  = fr_ifm_addr;
        first_len   = fr_ifm_len;
        if (fr_ifm_len != '0) begin
            first_state = ST_RD_IFM;
            first_valid = 1'b1;
        end else if (fr_wgt_len != '0) begin
            first_state = ST_RD_WGT;
            first_valid = 1'b1;
            first_sel   = RD_SEL_WGT;
            first_addr  = fr_wgt_addr;
            first_len   = fr_wgt_len;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_reg        <= ST_IDLE;
            ap_done_reg      <= 1'b0;
            ap_idle_reg      <= 1'b1;
            ap_ready_reg     <= 1'b0;
            rd_cmd_valid_reg <= 1'b0;
            rd_cmd_sel_reg   <= RD_SEL_IFM;
            rd_cmd_addr_reg  <= '0;
            rd_cmd_len_reg   <= '0;
            comp_start_reg   <= 1'b0;
            comp_ci_reg      <= '0;
            comp_co_reg      <= '0;
            wr_cmd_valid_reg <= 1'b0;
            wr_cmd_addr_reg  <= '0;
            wr_cmd_len_reg   <= '0;
            ifm_size_reg     <= '0;
            wgt_size_reg     <= '0;
            ofm_size_reg     <= '0;
            tile_num_reg     <= '0;
            tile_cnt_reg     <= '0;
            rd_out_reg       <= '0;
        end else begin
            ap_ready_reg   <= 1'b0;
            comp_start_reg <= 1'b0;
            rd_out_reg     <= rd_out_next;
            case (state_reg)
                ST_IDLE: begin
                    if (ap_start) begin
                        ap_ready_reg <= 1'b1;
                        ap_idle_reg  <= 1'b0;
                        comp_ci_reg  <= cfg_ci;
                        comp_co_reg  <= cfg_co;
                        ifm_size_reg <= ifm_size;
                        wgt_size_reg <= wgt_size;
                        ofm_size_reg <= ofm_size;
                        tile_num_reg <= tile_num;
                        tile_cnt_reg <= '0;
                        rd_out_reg   <= '0;
                        if (tile_num == '0) begin
                            state_reg <= ST_DONE;
                        end else begin
                            state_reg        <= first_state;
                            rd_cmd_valid_reg <= first_valid;
                            rd_cmd_sel_reg   <= first_sel;
                            rd_cmd_addr_reg  <= first_addr;
                            rd_cmd_len_reg   <= first_len;
                        end
                    end
                end
                ST_RD_IFM: begin
                    if (rd_cmd_ready) begin
                        if (wgt_size_reg != '0) begin
                            state_reg       <= ST_RD_WGT;
                            rd_cmd_sel_reg  <= RD_SEL_WGT;
                            rd_cmd_addr_reg <= wgt_ptr;
                            rd_cmd_len_reg  <= wgt_size_reg;
                        end else begin
                            state_reg        <= ST_WAIT_RD;
                            rd_cmd_valid_reg <= 1'b0;
                        end
                    end
                end
                ST_RD_WGT: begin
                    if (rd_cmd_ready) begin
                        state_reg        <= ST_WAIT_RD;
                        rd_cmd_valid_reg <= 1'b0;
                    end
                end
                ST_WAIT_RD: begin
                    if (rd_out_next == 2'd0) state_reg <= ST_COMP;
                end
                ST_COMP: begin
                    comp_start_reg <= 1'b1;
                    state_reg      <= ST_WAIT_COMP;
                end
                ST_WAIT_COMP: begin
                    if (comp_done) begin
                        if (ofm_size_reg != '0) begin
                            state_reg        <= ST_WR_OFM;
                            wr_cmd_valid_reg <= 1'b1;
                            wr_cmd_addr_reg  <= ofm_ptr;
                            wr_cmd_len_reg   <= ofm_size_reg;
                        end else begin
                            state_reg <= ST_NEXT;
                        end
                    end
                end
                ST_WR_OFM: begin
                    if (wr_cmd_ready) begin
                        state_reg        <= ST_WAIT_WR;
                        wr_cmd_valid_reg <= 1'b0;
                    end
                end
                ST_WAIT_WR: begin
                    if (wr_done) state_reg <= ST_NEXT;
                end
                ST_NEXT: begin
                    tile_cnt_reg <= tile_cnt_reg + 32'd1;
                    if (tile_cnt_reg + 32'd1 == tile_num_reg) begin
                        state_reg   <= ST_DONE;
                        ap_done_reg <= 1'b1;
                    end else begin
                        state_reg        <= first_state;
                        rd_cmd_valid_reg <= first_valid;
                        rd_cmd_sel_reg   <= first_sel;
                        rd_cmd_addr_reg  <= first_addr;
                        rd_cmd_len_reg   <= first_len;
                    end
                end
                ST_DONE: begin
                    // Continue is only honoured once ap_done is visible to the control slave.
                    if (ap_done_reg && ap_continue) begin
                        state_reg   <= ST_IDLE;
                        ap_done_reg <= 1'b0;
                        ap_idle_reg <= 1'b1;
                    end else begin
                        ap_done_reg <= 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign ap_done      = ap_done_reg;
    assign ap_idle      = ap_idle_reg;
    assign ap_ready     = ap_ready_reg;
    assign rd_cmd_valid = rd_cmd_valid_reg;
    assign rd_cmd_addr  = rd_cmd_addr_reg;
    assign rd_cmd_len   = rd_cmd_len_reg;
    assign rd_cmd_sel   = rd_cmd_sel_reg;
    assign comp_start   = comp_start_reg;
    assign comp_ci      = comp_ci_reg;
    assign comp_co      = comp_co_reg;
    assign wr_cmd_valid = wr_cmd_valid_reg;
    assign wr_cmd_addr  = wr_cmd_addr_reg;
    assign wr_cmd_len   = wr_cmd_len_reg;

endmodule

// File: tb/tb_krnl_acc_tile_sched.sv
// Randomised environment for krnl_acc_tile_sched, checked against an expected per-tile event list.
module tb_krnl_acc_tile_sched;

    logic        ACLK = 1'b0;
    logic        ARESETn;
    logic        ap_start, ap_continue, ap_done, ap_idle, ap_ready;
    logic [31:0] cfg_ci, cfg_co, ifm_size, wgt_size, ofm_size, tile_num;
    logic [63:0] ifm_addr_base, wgt_addr_base, ofm_addr_base;
    logic        rd_cmd_valid, rd_cmd_ready, rd_cmd_sel, rd_done;
    logic [63:0] rd_cmd_addr;
    logic [31:0] rd_cmd_len;
    logic        comp_start, comp_done;
    logic [31:0] comp_ci, comp_co;
    logic        wr_cmd_valid, wr_cmd_ready, wr_done;
    logic [63:0] wr_cmd_addr;
    logic [31:0] wr_cmd_len;

    always #5 ACLK = ~ACLK;

    krnl_acc_tile_sched dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .ap_start(ap_start), .ap_continue(ap_continue),
        .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
        .cfg_ci(cfg_ci), .cfg_co(cfg_co),
        .ifm_size(ifm_size), .wgt_size(wgt_size), .ofm_size(ofm_size), .tile_num(tile_num),
        .ifm_addr_base(ifm_addr_base), .wgt_addr_base(wgt_addr_base), .ofm_addr_base(ofm_addr_base),
        .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready), .rd_cmd_addr(rd_cmd_addr),
        .rd_cmd_len(rd_cmd_len), .rd_cmd_sel(rd_cmd_sel), .rd_done(rd_done),
        .comp_start(comp_start), .comp_ci(comp_ci), .comp_co(comp_co), .comp_done(comp_done),
        .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready), .wr_cmd_addr(wr_cmd_addr),
        .wr_cmd_len(wr_cmd_len), .wr_done(wr_done)
    );

    typedef struct {
        int          kind;   // 0 read, 1 compute start, 2 write
        logic        sel;
        logic [63:0] addr;
        logic [31:0] len;
    } ev_t;

    ev_t exp_q[$];
    int  rd_due_q[$];
    int  n_checks = 0;
    int  n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag, input int kind, input logic sel,
                             input logic [63:0] addr, input logic [31:0] len);
        ev_t e;
        check_val({tag, "_expected"}, exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check_val({tag, "_kind"}, e.kind, kind);
            if (kind != 1) begin
                check_val({tag, "_addr"}, addr, e.addr);
                check_val({tag, "_len"}, len, e.len);
            end
            if (kind == 0) check_val({tag, "_sel"}, sel, e.sel);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_idle"}, ap_idle, 1);
        check_val({tag, "_done"}, ap_done, 0);
        check_val({tag, "_ready"}, ap_ready, 0);
        check_val({tag, "_rd_valid"}, rd_cmd_valid, 0);
        check_val({tag, "_rd_addr"}, rd_cmd_addr, 0);
        check_val({tag, "_rd_len"}, rd_cmd_len, 0);
        check_val({tag, "_rd_sel"}, rd_cmd_sel, 0);
        check_val({tag, "_comp_start"}, comp_start, 0);
        check_val({tag, "_comp_ci"}, comp_ci, 0);
        check_val({tag, "_comp_co"}, comp_co, 0);
        check_val({tag, "_wr_valid"}, wr_cmd_valid, 0);
        check_val({tag, "_wr_addr"}, wr_cmd_addr, 0);
        check_val({tag, "_wr_len"}, wr_cmd_len, 0);
    endtask

    function automatic int pick(input int s);
        return (s < 0) ? int'($urandom_range(0, 3)) : s;
    endfunction

    task automatic clear_inputs();
        rd_cmd_ready = 0; rd_done = 0; comp_done = 0;
        wr_cmd_ready = 0; wr_done = 0; ap_continue = 0;
    endtask

    // stall/rd_dly < 0 mean random; hold keeps ap_start high through DONE; abort resets at the first comp_start.
    task automatic run_job(input int tiles, input logic [63:0] ib, input logic [63:0] wb, input logic [63:0] ob,
                           input logic [31:0] is, input logic [31:0] ws, input logic [31:0] os,
                           input int stall, input int rd_dly, input bit hold, input int cont_dly,
                           input bit abort);
        ev_t e;
        int cyc, rd_hs, rd_dn, comps, due;
        int rd_stall, wr_stall, rd_tgt, wr_tgt, comp_due, wr_due;
        bit rd_wait, wr_wait, done_seen, aborted;
        logic [63:0] rd_a_s, wr_a_s;
        logic [31:0] rd_l_s, wr_l_s, ci, co;
        logic rd_s_s;
        ci = $urandom; co = $urandom;
        exp_q.delete(); rd_due_q.delete();
        for (int i = 0; i < tiles; i++) begin
            if (is != 0) begin e.kind = 0; e.sel = 0; e.addr = ib + 64'(i) * {32'd0, is}; e.len = is; exp_q.push_back(e); end
            if (ws != 0) begin e.kind = 0; e.sel = 1; e.addr = wb + 64'(i) * {32'd0, ws}; e.len = ws; exp_q.push_back(e); end
            e.kind = 1; e.sel = 0; e.addr = 0; e.len = 0; exp_q.push_back(e);
            if (os != 0) begin e.kind = 2; e.sel = 0; e.addr = ob + 64'(i) * {32'd0, os}; e.len = os; exp_q.push_back(e); end
        end
        cfg_ci = ci; cfg_co = co; tile_num = tiles;
        ifm_size = is; wgt_size = ws; ofm_size = os;
        ifm_addr_base = ib; wgt_addr_base = wb; ofm_addr_base = ob;
        ap_start = 1;
        @(negedge ACLK);
        check_val("start_ready", ap_ready, 1);
        check_val("start_idle", ap_idle, 0);
        if (tiles != 0 && is != 0) check_val("start_rd_valid", rd_cmd_valid, 1);
        if (tiles == 0) check_val("zero_no_rd", rd_cmd_valid, 0);
        if (!hold) ap_start = 0;
        cyc = 0; rd_hs = 0; rd_dn = 0; comps = 0; comp_due = -1; wr_due = -1;
        rd_stall = 0; wr_stall = 0; rd_tgt = pick(stall); wr_tgt = pick(stall);
        rd_wait = 0; wr_wait = 0; done_seen = 0; aborted = 0;
        rd_a_s = 0; wr_a_s = 0; rd_l_s = 0; wr_l_s = 0; rd_s_s = 0;
        while (cyc < 3000) begin
            if (cyc > 0) check_val("ready_once", ap_ready, 0);
            if (ap_done) begin done_seen = 1; break; end
            clear_inputs();
            if (comp_start) begin
                $display("comp_start tile=%0d", comps);
                pop_check("comp", 1, 0, 0, 0);
                check_val("comp_after_rd_done", rd_dn, rd_hs);
                check_val("comp_ci", comp_ci, ci);
                check_val("comp_co", comp_co, co);
                comps++;
                if (abort) begin ARESETn = 0; aborted = 1; break; end
                comp_due = cyc + int'($urandom_range(0, 3));
            end
            if (comp_due == cyc) begin comp_done = 1; comp_due = -1; end
            if (rd_wait) begin
                check_val("rd_valid_hold", rd_cmd_valid, 1);
                check_val("rd_addr_stable", rd_cmd_addr, rd_a_s);
                check_val("rd_len_stable", rd_cmd_len, rd_l_s);
                check_val("rd_sel_stable", rd_cmd_sel, rd_s_s);
                rd_wait = 0;
            end
            if (rd_cmd_valid) begin
                if (rd_stall < rd_tgt) begin
                    rd_stall++; rd_wait = 1;
                    rd_a_s = rd_cmd_addr; rd_l_s = rd_cmd_len; rd_s_s = rd_cmd_sel;
                end else begin
                    rd_cmd_ready = 1; rd_stall = 0; rd_tgt = pick(stall);
                    $display("rd  sel=%0d addr=%h len=%h", rd_cmd_sel, rd_cmd_addr, rd_cmd_len);
                    pop_check("rd", 0, rd_cmd_sel, rd_cmd_addr, rd_cmd_len);
                    rd_hs++;
                    due = cyc + ((rd_dly < 0) ? int'($urandom_range(0, 3)) : rd_dly);
                    if (rd_due_q.size() > 0 && due <= rd_due_q[$]) due = rd_due_q[$] + 1;
                    rd_due_q.push_back(due);
                end
            end
            if (rd_due_q.size() > 0 && rd_due_q[0] <= cyc) begin
                rd_done = 1; void'(rd_due_q.pop_front()); rd_dn++;
            end
            if (wr_wait) begin
                check_val("wr_valid_hold", wr_cmd_valid, 1);
                check_val("wr_addr_stable", wr_cmd_addr, wr_a_s);
                check_val("wr_len_stable", wr_cmd_len, wr_l_s);
                wr_wait = 0;
            end
            if (wr_cmd_valid) begin
                if (wr_stall < wr_tgt) begin
                    wr_stall++; wr_wait = 1; wr_a_s = wr_cmd_addr; wr_l_s = wr_cmd_len;
                end else begin
                    wr_cmd_ready = 1; wr_stall = 0; wr_tgt = pick(stall);
                    $display("wr  addr=%h len=%h", wr_cmd_addr, wr_cmd_len);
                    pop_check("wr", 2, 0, wr_cmd_addr, wr_cmd_len);
                    wr_due = cyc + 1 + int'($urandom_range(0, 3));
                end
            end
            if (wr_due == cyc) begin wr_done = 1; wr_due = -1; end
            // Control noise that must be ignored while a run is in flight.
            if (!hold) ap_start = ($urandom_range(0, 7) == 0);
            ap_continue = ($urandom_range(0, 7) == 0);
            @(negedge ACLK);
            cyc++;
        end
        clear_inputs();
        if (!hold) ap_start = 0;
        if (aborted) return;
        check_val("done_reached", done_seen, 1);
        check_val("events_left", exp_q.size(), 0);
        check_val("comp_count", comps, tiles);
        check_val("wr_done_before_ap_done", wr_due, -1);
        if (tiles == 0) check_val("zero_done_latency", cyc, 1);
        $display("job tiles=%0d done after %0d cycles", tiles, cyc + 1);
        for (int i = 0; i < cont_dly; i++) begin
            @(negedge ACLK);
            check_val("done_hold", ap_done, 1);
            check_val("hold_no_ready", ap_ready, 0);
            check_val("hold_no_rd", rd_cmd_valid, 0);
        end
        ap_continue = 1;
        @(negedge ACLK);
        ap_continue = 0;
        check_val("cont_done_low", ap_done, 0);
        check_val("cont_idle", ap_idle, 1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] b0, b1, b2;
        logic [31:0] s0, s1, s2;
        ARESETn = 0; ap_start = 0; clear_inputs();
        cfg_ci = 0; cfg_co = 0; ifm_size = 0; wgt_size = 0; ofm_size = 0; tile_num = 0;
        ifm_addr_base = 0; wgt_addr_base = 0; ofm_addr_base = 0;
        repeat (3) @(negedge ACLK);
        check_reset_vals("rst");
        ARESETn = 1;
        @(negedge ACLK);
        check_reset_vals("post_rst");

        // Spurious completions and continue while idle must not disturb anything.
        rd_done = 1; comp_done = 1; wr_done = 1; ap_continue = 1;
        @(negedge ACLK);
        clear_inputs();
        @(negedge ACLK);
        check_val("spurious_idle", ap_idle, 1);
        check_val("spurious_rd", rd_cmd_valid, 0);
        check_val("spurious_done", ap_done, 0);

        $display("-- single tile");
        run_job(1, 64'h1000, 64'h2000, 64'h3000, 32'h100, 32'h40, 32'h80, 0, 2, 0, 0, 0);
        $display("-- three tiles, stalled commands");
        run_job(3, 64'h1000, 64'h8000, 64'h9000, 32'h100, 32'h40, 32'h80, 5, -1, 0, 2, 0);
        $display("-- zero tiles");
        run_job(0, 64'h1000, 64'h2000, 64'h3000, 32'h100, 32'h40, 32'h80, 0, 0, 0, 0, 0);
        $display("-- coincident read completions");
        run_job(2, 64'h4000, 64'h5000, 64'h6000, 32'h20, 32'h30, 32'h40, 0, 1, 0, 0, 0);
        run_job(2, 64'h4000, 64'h5000, 64'h6000, 32'h20, 32'h30, 32'h40, 0, 0, 0, 0, 0);
        $display("-- ap_start held through done");
        run_job(1, 64'hA000, 64'hB000, 64'hC000, 32'h10, 32'h10, 32'h10, 0, -1, 1, 20, 0);
        run_job(2, 64'hA100, 64'hB100, 64'hC100, 32'h10, 32'h0, 32'h10, 0, -1, 0, 1, 0);
        $display("-- reset during compute");
        run_job(2, 64'h7000, 64'h7100, 64'h7200, 32'h8, 32'h8, 32'h8, 0, -1, 0, 0, 1);
        @(negedge ACLK);
        check_reset_vals("midrun_rst");
        ARESETn = 1; comp_done = 1;
        @(negedge ACLK);
        comp_done = 0;
        repeat (3) begin
            @(negedge ACLK);
            check_val("late_comp_idle", ap_idle, 1);
            check_val("late_comp_wr", wr_cmd_valid, 0);
            check_val("late_comp_done", ap_done, 0);
        end
        $display("-- pointer wrap");
        run_job(2, 64'hFFFF_FFFF_FFFF_FF00, 64'hFFFF_FFFF_FFFF_FF00, 64'hFFFF_FFFF_FFFF_FF00,
                32'h100, 32'h100, 32'h100, -1, -1, 0, 0, 0);
        $display("-- randomised jobs");
        for (int j = 0; j < 10; j++) begin
            b0 = {$urandom, $urandom}; b1 = {$urandom, $urandom}; b2 = {$urandom, $urandom};
            s0 = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 'h400));
            s1 = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 'h400));
            s2 = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 'h400));
            run_job(int'($urandom_range(1, 4)), b0, b1, b2, s0, s1, s2, -1, -1, 0,
                    int'($urandom_range(0, 3)), 0);
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
